data_mem_clr: RTL and testbench

//  Parametrised single-port data memory for the core datapath; next generation of the 8x256 DataMem.
//  - Generalised width/depth.
//  - Registered (1-cycle) read with a valid strobe instead of a combinational/tri-state read.
//  - Write-first same-address forwarding.
//  - Hardware clear sweep after Reset, with a Ready handshake.

---
 rtl/data_mem_clr_pkg.sv | 32 +++
 rtl/data_mem_clr_if.sv | 24 ++
 rtl/data_mem_clr_core.sv | 30 +++
 rtl/data_mem_clr.sv | 121 ++++++++++++
 tb/tb_data_mem_clr.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_clr_pkg.sv
// Shared types and sizing helpers for the clearable data memory.
package data_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Source of DataOut after the most recent accepted read
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_CORE = 2'd1,
    SEL_BYP  = 2'd2
  } rd_sel_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Word-index width: enough for DEPTH, at least 1, never wider than the address
  function automatic int idx_w(input int depth, input int addr_w);
    int w;
    w = clog2(depth);
    if (w < 1) w = 1;
    if (w > addr_w) w = addr_w;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_clr_if.sv
// Request/response bundle between the datapath and the data memory.
interface data_mem_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              WriteEn;
  logic              ReadEn;
  logic [ADDR_W-1:0] DataAddress;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;
  logic              RdValid;
  logic              Ready;
  logic              AddrErr;

  modport master (
    output WriteEn, ReadEn, DataAddress, DataIn,
    input  DataOut, RdValid, Ready, AddrErr
  );

  modport slave (
    input  WriteEn, ReadEn, DataAddress, DataIn,
    output DataOut, RdValid, Ready, AddrErr
  );
endinterface

// File: rtl/data_mem_clr_core.sv
// Plain storage: one synchronous write port, one registered read port, no reset.
module data_mem_core
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  localparam int IDX_W = idx_w(DEPTH, ADDR_W)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read returns pre-write contents; same-address forwarding lives in the wrapper
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_clr.sv
// Data memory with post-reset clear sweep, Ready handshake, write-first forwarding
// and out-of-range detection.
module data_mem_clr
  import data_mem_pkg::*;
#(
  parameter int              DATA_W         = 8,
  parameter int              ADDR_W         = 8,
  parameter int              DEPTH          = 256,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
  input logic           Clk,
  input logic           Reset,
  data_mem_clr_if.slave bus
);

  localparam int               IDX_W   = idx_w(DEPTH, ADDR_W);
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic              rd_vld_q, rd_vld_d;
  logic              addr_err_q, addr_err_d;
  rd_sel_e           sel_q, sel_d;
  logic [DATA_W-1:0] byp_q, byp_d;

  logic              ready, in_range, acc_rd, acc_wr;
  logic              mem_we, mem_re;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata, core_rdata;

  assign ready    = (state_q == ST_IDLE) && !Reset;
  assign in_range = {1'b0, bus.DataAddress} < DEPTH_X;
  assign acc_rd   = ready && bus.ReadEn;
  assign acc_wr   = ready && bus.WriteEn;
  assign mem_re   = acc_rd && in_range;

  // Sweep owns the write port while clearing
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.DataAddress[IDX_W-1:0];
    mem_wdata = bus.DataIn;
    if (state_q == ST_CLEAR && !Reset) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = INIT_VAL;
    end else if (acc_wr && in_range) begin
      mem_we = 1'b1;
    end
  end

  data_mem_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (Clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (bus.DataAddress[IDX_W-1:0]),
    .rdata_o (core_rdata)
  );

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rd_vld_d   = acc_rd;
    addr_err_d = (acc_rd || acc_wr) && !in_range;
    sel_d      = sel_q;
    byp_d      = byp_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST) state_d = ST_IDLE;
    end
    // Address is shared, so a concurrent write always hits the read address
    if (acc_rd) begin
      if (!in_range) begin
        sel_d = SEL_ZERO;
      end else if (bus.WriteEn) begin
        sel_d = SEL_BYP;
        byp_d = bus.DataIn;
      end else begin
        sel_d = SEL_CORE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_ptr_q  <= '0;
      rd_vld_q   <= 1'b0;
      addr_err_q <= 1'b0;
      sel_q      <= SEL_ZERO;
      byp_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_vld_q   <= rd_vld_d;
      addr_err_q <= addr_err_d;
      sel_q      <= sel_d;
      byp_q      <= byp_d;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_CORE: bus.DataOut = core_rdata;
      SEL_BYP:  bus.DataOut = byp_q;
      default:  bus.DataOut = '0;
    endcase
  end

  assign bus.RdValid = rd_vld_q;
  assign bus.AddrErr = addr_err_q;
  assign bus.Ready   = ready;

endmodule

// File: tb/tb_data_mem_clr.sv
// Directed bench for data_mem_clr: sweep/no-sweep instances checked against a behavioural model.
module tb_data_mem_clr;

  localparam int          DW = 8;
  localparam int          AW = 5;
  localparam int          D  = 16;
  localparam logic [7:0]  IV = 8'hA5;

  logic Clk = 1'b0;
  logic rst1, rst0;
  always #5 Clk = ~Clk;

  data_mem_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  data_mem_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  data_mem_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .CLEAR_ON_RESET(1'b1), .INIT_VAL(IV))
    dut  (.Clk(Clk), .Reset(rst1), .bus(bus1));
  data_mem_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .CLEAR_ON_RESET(1'b0), .INIT_VAL(IV))
    dut0 (.Clk(Clk), .Reset(rst0), .bus(bus0));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model, index 0 = sweeping instance, 1 = non-sweeping instance
  logic [7:0] m_mem   [2][D];
  bit         m_known [2][D];
  bit         m_on  [2];
  bit         m_idle[2];
  int         m_cnt [2];
  logic       m_vld [2];
  logic       m_err [2];
  logic [7:0] m_dout[2];
  bit         m_dk  [2];

  task automatic model_step(input int k, input bit clr, input logic rst, input logic we,
                            input logic re, input logic [AW-1:0] a, input logic [7:0] d);
    bit oor;
    oor = int'(a) >= D;
    if (rst) begin
      m_on[k] = 1; m_idle[k] = !clr; m_cnt[k] = 0;
      m_vld[k] = 0; m_err[k] = 0; m_dout[k] = 8'h00; m_dk[k] = 1;
    end else if (m_on[k] && !m_idle[k]) begin
      m_cnt[k]++;
      m_vld[k] = 0; m_err[k] = 0;
      if (m_cnt[k] == D) begin
        m_idle[k] = 1;
        for (int i = 0; i < D; i++) begin m_mem[k][i] = IV; m_known[k][i] = 1; end
      end
    end else if (m_on[k]) begin
      m_vld[k] = re;
      m_err[k] = (re || we) && oor;
      if (re) begin
        if (oor)     begin m_dout[k] = 8'h00; m_dk[k] = 1; end
        else if (we) begin m_dout[k] = d;     m_dk[k] = 1; end
        else begin m_dout[k] = m_mem[k][a[3:0]]; m_dk[k] = m_known[k][a[3:0]]; end
      end
      if (we && !oor) begin m_mem[k][a[3:0]] = d; m_known[k][a[3:0]] = 1; end
    end
  endtask

  always @(posedge Clk) begin
    model_step(0, 1'b1, rst1, bus1.WriteEn, bus1.ReadEn, bus1.DataAddress, bus1.DataIn);
    model_step(1, 1'b0, rst0, bus0.WriteEn, bus0.ReadEn, bus0.DataAddress, bus0.DataIn);
  end

  task automatic cmp(input int k, input logic rst, input logic rdy, input logic vld,
                     input logic err, input logic [7:0] dout);
    if (m_on[k]) begin
      chk($sformatf("m%0d_ready", k),   32'(rdy), 32'(m_idle[k] && !rst));
      chk($sformatf("m%0d_rdvalid", k), 32'(vld), 32'(m_vld[k]));
      chk($sformatf("m%0d_addrerr", k), 32'(err), 32'(m_err[k]));
      if (m_dk[k]) chk($sformatf("m%0d_dataout", k), 32'(dout), 32'(m_dout[k]));
    end
  endtask

  always @(negedge Clk) begin
    cmp(0, rst1, bus1.Ready, bus1.RdValid, bus1.AddrErr, bus1.DataOut);
    cmp(1, rst0, bus0.Ready, bus0.RdValid, bus0.AddrErr, bus0.DataOut);
  end

  task automatic tick;
    @(posedge Clk);
    #2;
  endtask

  task automatic idle1;
    bus1.WriteEn = 0; bus1.ReadEn = 0; bus1.DataIn = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst1 = 1; rst0 = 1;
    idle1(); bus1.DataAddress = '0;
    bus0.WriteEn = 0; bus0.ReadEn = 0; bus0.DataAddress = '0; bus0.DataIn = 8'h00;

    // 1: reset state, sweep length, all words cleared
    tick; tick;
    chk("t1_rst_ready",   32'(bus1.Ready),   32'd0);
    chk("t1_rst_dout",    32'(bus1.DataOut), 32'h00);
    chk("t1_rst_rdvalid", 32'(bus1.RdValid), 32'd0);
    chk("t1_rst_addrerr", 32'(bus1.AddrErr), 32'd0);
    rst1 = 0; rst0 = 0;
    n = 0;
    while (!bus1.Ready && n < 40) begin tick; n++; end
    chk("t1_sweep_edges", 32'(n), 32'd16);
    bus1.ReadEn = 1;
    for (int a = 0; a < D; a++) begin
      bus1.DataAddress = AW'(a);
      tick;
      chk($sformatf("t1_rd%0d_dout", a),  32'(bus1.DataOut), 32'hA5);
      chk($sformatf("t1_rd%0d_valid", a), 32'(bus1.RdValid), 32'd1);
    end
    idle1(); tick;

    // 2: write then read, DataOut holds
    bus1.WriteEn = 1; bus1.DataAddress = 5'd4; bus1.DataIn = 8'h3C; tick;
    bus1.WriteEn = 0; bus1.ReadEn = 1; tick;
    chk("t2_dout",  32'(bus1.DataOut), 32'h3C);
    chk("t2_valid", 32'(bus1.RdValid), 32'd1);
    bus1.ReadEn = 0; tick;
    chk("t2_valid_fall", 32'(bus1.RdValid), 32'd0);
    chk("t2_hold1",      32'(bus1.DataOut), 32'h3C);
    tick;
    chk("t2_hold2",      32'(bus1.DataOut), 32'h3C);

    // 3: same-cycle write+read forwards the write data
    bus1.WriteEn = 1; bus1.ReadEn = 1; bus1.DataAddress = 5'd7; bus1.DataIn = 8'h5A; tick;
    chk("t3_fwd_dout",  32'(bus1.DataOut), 32'h5A);
    chk("t3_fwd_valid", 32'(bus1.RdValid), 32'd1);
    bus1.WriteEn = 0; bus1.DataIn = 8'h00; tick;
    chk("t3_reread", 32'(bus1.DataOut), 32'h5A);
    idle1(); tick;

    // 4: reset mid-sweep restarts it; requests during the sweep are ignored
    rst1 = 1; tick; rst1 = 0;
    for (int i = 0; i < 8; i++) tick;
    rst1 = 1;
    bus1.WriteEn = 1; bus1.ReadEn = 1; bus1.DataAddress = 5'd4; bus1.DataIn = 8'h11;
    tick;
    rst1 = 0;
    n = 0;
    while (!bus1.Ready && n < 40) begin
      tick; n++;
      chk("t4_no_rdvalid", 32'(bus1.RdValid), 32'd0);
      if (n == 10) idle1();
    end
    chk("t4_sweep_edges", 32'(n), 32'd16);
    bus1.ReadEn = 1; bus1.DataAddress = 5'd4; tick;
    chk("t4_rd4", 32'(bus1.DataOut), 32'hA5);
    bus1.DataAddress = 5'd7; tick;
    chk("t4_rd7", 32'(bus1.DataOut), 32'hA5);
    idle1(); tick;

    // 5: out-of-range write/read
    bus1.WriteEn = 1; bus1.DataAddress = 5'd20; bus1.DataIn = 8'hFF; tick;
    chk("t5_wr_err",   32'(bus1.AddrErr), 32'd1);
    chk("t5_wr_valid", 32'(bus1.RdValid), 32'd0);
    bus1.WriteEn = 0; bus1.ReadEn = 1; tick;
    chk("t5_rd_err",   32'(bus1.AddrErr), 32'd1);
    chk("t5_rd_dout",  32'(bus1.DataOut), 32'h00);
    chk("t5_rd_valid", 32'(bus1.RdValid), 32'd1);
    idle1(); tick;
    chk("t5_err_clr", 32'(bus1.AddrErr), 32'd0);
    bus1.WriteEn = 1; bus1.DataAddress = 5'd20; tick;
    bus1.DataAddress = 5'd2; bus1.DataIn = 8'h42; tick;
    chk("t5_inrange_clr", 32'(bus1.AddrErr), 32'd0);
    bus1.WriteEn = 0; bus1.ReadEn = 1;
    for (int a = 0; a < D; a++) begin
      bus1.DataAddress = AW'(a);
      tick;
      chk($sformatf("t5_rd%0d", a), 32'(bus1.DataOut), (a == 2) ? 32'h42 : 32'hA5);
    end
    idle1(); tick;

    // 6: no-sweep instance is ready immediately
    rst0 = 1; tick; rst0 = 0; tick;
    chk("t6_ready", 32'(bus0.Ready), 32'd1);
    bus0.WriteEn = 1; bus0.DataAddress = 5'd15; bus0.DataIn = 8'h81; tick;
    bus0.WriteEn = 0; bus0.ReadEn = 1; tick;
    chk("t6_dout",  32'(bus0.DataOut), 32'h81);
    chk("t6_valid", 32'(bus0.RdValid), 32'd1);
    bus0.ReadEn = 0; tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
